bk_add_seq: RTL and testbench

BK_ADD_SEQ -- requirements
Module: bk_add_seq

---
 rtl/bk_adder_pkg.sv | 12 +
 rtl/bk_adder_32bit.sv | 43 ++++
 rtl/bk_add_seq.sv | 141 ++++++++++++++
 tb/tb_bk_add_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_adder_pkg.sv
// Shared definitions for the sequential multi-limb adder: word width and FSM state encoding.
package bk_adder_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/bk_adder_32bit.sv
// 32-bit Brent-Kung parallel-prefix adder with carry-in; purely combinational.
module bk_adder_32bit
    import bk_adder_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              cin,
    output logic [WORD_W-1:0] sum,
    output logic              cout
);

    logic [WORD_W-1:0] p;
    logic [WORD_W-1:0] gg;
    logic [WORD_W-1:0] pp;

    assign p = a ^ b;

    always_comb begin
        gg = a & b;
        pp = p;
        // Fold cin into bit 0 so gg[i] becomes the carry out of bit i.
        gg[0] = gg[0] | (p[0] & cin);
        for (int l = 0; l < 5; l++) begin
            for (int i = 0; i < 32; i++) begin
                if (((i + 1) % (2 << l)) == 0) begin
                    gg[5'(i)] = gg[5'(i)] | (pp[5'(i)] & gg[5'(i - (1 << l))]);
                    pp[5'(i)] = pp[5'(i)] & pp[5'(i - (1 << l))];
                end
            end
        end
        for (int l = 3; l >= 0; l--) begin
            for (int i = 0; i < 32; i++) begin
                if ((((i + 1) % (2 << l)) == (1 << l)) && (i + 1 >= 3 * (1 << l))) begin
                    gg[5'(i)] = gg[5'(i)] | (pp[5'(i)] & gg[5'(i - (1 << l))]);
                end
            end
        end
    end

    assign sum  = p ^ {gg[WORD_W-2:0], cin};
    assign cout = gg[WORD_W-1];

endmodule

// File: rtl/bk_add_seq.sv
// Two-requester round-robin front end that time-shares one 32-bit adder over LIMBS words.
// Optional signed-overflow output rsp_ovf is built when BK_ADD_SEQ_OVF_EN is defined.
module bk_add_seq
    import bk_adder_pkg::*;
#(
    parameter int unsigned LIMBS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [WORD_W*LIMBS-1:0] req_a0,
    input  logic [WORD_W*LIMBS-1:0] req_b0,
    input  logic [WORD_W*LIMBS-1:0] req_a1,
    input  logic [WORD_W*LIMBS-1:0] req_b1,
    input  logic [1:0]              req_cin,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_id,
    output logic [WORD_W*LIMBS-1:0] rsp_sum,
    output logic                    rsp_cout
`ifdef BK_ADD_SEQ_OVF_EN
    ,
    output logic                    rsp_ovf
`endif
);

    localparam int unsigned W  = WORD_W * LIMBS;
    localparam int unsigned KW = $clog2(LIMBS);
    localparam logic [KW-1:0] LAST = KW'(LIMBS - 1);

    state_t            state_q, state_d;
    logic              ptr_q;
    logic              grant_id;
    logic              accept;
    logic [W-1:0]      a_q, b_q, sum_q;
    logic              carry_q, cout_q, id_q;
    logic [KW-1:0]     k_q;
    logic [WORD_W-1:0] add_sum;
    logic              add_cout;

    bk_adder_32bit u_adder (
        .a    (a_q[WORD_W-1:0]),
        .b    (b_q[WORD_W-1:0]),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_comb begin
        grant_id = ptr_q;
        if (req_valid == 2'b01) begin
            grant_id = 1'b0;
        end else if (req_valid == 2'b10) begin
            grant_id = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (k_q == LAST) state_d = DONE;
            DONE:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant is masked by rst so nothing is offered while reset is held.
    always_comb begin
        req_ready = 2'b00;
        if ((state_q == IDLE) && !rst && (req_valid != 2'b00)) begin
            req_ready[grant_id] = 1'b1;
        end
        rsp_valid = (state_q == DONE);
    end

    // Operands shift down one limb per RUN cycle; results shift in from the top,
    // so after LIMBS cycles limb 0 sits at the LSBs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            id_q    <= 1'b0;
            k_q     <= '0;
        end else if (accept) begin
            a_q     <= grant_id ? req_a1 : req_a0;
            b_q     <= grant_id ? req_b1 : req_b0;
            carry_q <= req_cin[grant_id];
            id_q    <= grant_id;
            k_q     <= '0;
            ptr_q   <= ~grant_id;
        end else if (state_q == RUN) begin
            a_q     <= a_q >> WORD_W;
            b_q     <= b_q >> WORD_W;
            sum_q   <= {add_sum, sum_q[W-1:WORD_W]};
            carry_q <= add_cout;
            k_q     <= k_q + KW'(1);
            if (k_q == LAST) begin
                cout_q <= add_cout;
            end
        end
    end

`ifdef BK_ADD_SEQ_OVF_EN
    logic ovf_q;
    logic msb_cin;

    // Carry into the MSB recovered from the MSB sum bit.
    assign msb_cin = a_q[WORD_W-1] ^ b_q[WORD_W-1] ^ add_sum[WORD_W-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if ((state_q == RUN) && (k_q == LAST) && !accept) begin
            ovf_q <= msb_cin ^ add_cout;
        end
    end

    assign rsp_ovf = ovf_q;
`endif

    assign rsp_sum  = sum_q;
    assign rsp_cout = cout_q;
    assign rsp_id   = id_q;

endmodule

// File: tb/tb_bk_add_seq.sv
// Scoreboard bench for bk_add_seq: directed vectors, monitor pops expected responses on handshake.
module tb_bk_add_seq;

    localparam int unsigned LIMBS = 4;
    localparam int unsigned W     = 32 * LIMBS;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         id;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_valid = 2'b00;
    logic [1:0]   req_ready;
    logic [W-1:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [1:0]   req_cin = 2'b00;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic         rsp_id;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
`ifdef BK_ADD_SEQ_OVF_EN
    logic         rsp_ovf;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    bk_add_seq #(.LIMBS(LIMBS)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
`ifdef BK_ADD_SEQ_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic i,
                                input logic o);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.id   = i;
        e.ovf  = o;
        return e;
    endfunction

    // Monitor: handshake completes on the following rising edge.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got id %0d sum %0h, expected none", rsp_id, rsp_sum);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_sum", rsp_sum, mon_e.sum);
                chk("rsp_cout", W'(rsp_cout), W'(mon_e.cout));
                chk("rsp_id", W'(rsp_id), W'(mon_e.id));
`ifdef BK_ADD_SEQ_OVF_EN
                chk("rsp_ovf", W'(rsp_ovf), W'(mon_e.ovf));
`endif
            end
        end
    end

    // Called at posedge+#1; returns at posedge+#1 after accept (or after rsp_valid if chk_lat).
    task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input bit push, input bit chk_lat, input exp_t e);
        int n;
        int lat;
        if (id) begin
            req_a1 = a;
            req_b1 = b;
        end else begin
            req_a0 = a;
            req_b0 = b;
        end
        req_cin[id]   = cin;
        req_valid[id] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[id] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[id]) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: got no grant for id %0d, expected grant", id);
            req_valid[id] = 1'b0;
            return;
        end
        @(posedge clk);
        if (push) sb.push_back(e);
        #1;
        req_valid[id] = 1'b0;
        if (chk_lat) begin
            lat = 0;
            for (int k = 1; k <= int'(LIMBS) + 4; k++) begin
                @(posedge clk);
                #1;
                if (rsp_valid) begin
                    lat = k;
                    break;
                end
            end
            chk("latency", W'(lat), W'(LIMBS));
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        // Reset state, with requests presented to confirm grants stay masked.
        req_valid = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", W'(req_ready), W'(2'b00));
        chk("rst_rsp_valid", W'(rsp_valid), '0);
        chk("rst_rsp_sum", rsp_sum, '0);
        chk("rst_rsp_cout", W'(rsp_cout), '0);
        chk("rst_rsp_id", W'(rsp_id), '0);
        req_valid = 2'b00;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // All-ones plus carry-in wraps to zero with carry out.
        issue(1'b0, {4{32'hFFFFFFFF}}, '0, 1'b1, 1, 1, mk('0, 1'b1, 1'b0, 1'b0));
        drain();

        // Reset mid-operation after two limbs; the pointer was left at 1.
        issue(1'b1, 128'h11111111_22222222_33333333_44444444,
              128'h01010101_01010101_01010101_01010101, 1'b0, 0, 0, mk('0, 1'b0, 1'b0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", W'(rsp_valid), '0);
        chk("midrst_rsp_sum", rsp_sum, '0);
        chk("midrst_rsp_cout", W'(rsp_cout), '0);
        chk("midrst_rsp_id", W'(rsp_id), '0);
        chk("midrst_req_ready", W'(req_ready), '0);
        req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("inrst_req_ready", W'(req_ready), '0);
        end
        req_valid = 2'b00;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("postrst_rsp_valid", W'(rsp_valid), '0);
        end

        // Both requesters at once: pointer is back at 0, so id0 goes first.
        req_a0 = 128'd56;
        req_b0 = 128'd78;
        req_a1 = 128'd567;
        req_b1 = 128'd435;
        req_cin = 2'b10;
        req_valid = 2'b11;
        @(negedge clk);
        chk("rr_first_grant", W'(req_ready), W'(2'b01));
        @(posedge clk);
        sb.push_back(mk(128'd134, 1'b0, 1'b0, 1'b0));
        #1;
        req_valid[0] = 1'b0;
        req_a0 = '1;
        req_b0 = '1;
        req_cin[0] = 1'b1;
        issue(1'b1, 128'd567, 128'd435, 1'b1, 1, 0, mk(128'd1003, 1'b0, 1'b1, 1'b0));
        req_a1 = '1;
        drain();

        // Backpressure in DONE with a pending request that must not be granted.
        rsp_ready = 1'b0;
        issue(1'b1, 128'h00000001_FFFFFFFF_00000000_FFFFFFFF,
              128'h00000000_00000001_FFFFFFFF_00000001, 1'b0, 1, 1,
              mk(128'h00000002_00000001_00000000_00000000, 1'b0, 1'b1, 1'b0));
        req_a0 = 128'd5;
        req_b0 = 128'd7;
        req_cin[0] = 1'b0;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("hold_rsp_valid", W'(rsp_valid), W'(1'b1));
            chk("hold_rsp_sum", rsp_sum, 128'h00000002_00000001_00000000_00000000);
            chk("hold_req_ready", W'(req_ready), '0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_done", W'(req_ready), W'(2'b01));
        issue(1'b0, 128'd5, 128'd7, 1'b0, 1, 1, mk(128'd12, 1'b0, 1'b0, 1'b0));
        drain();

        // Carry across limb 0/1 boundary, then all-ones with carry-in.
        issue(1'b0, 128'h80000000, 128'h80000000, 1'b0, 1, 1,
              mk(128'h1_00000000, 1'b0, 1'b0, 1'b0));
        drain();
        issue(1'b1, {4{32'hFFFFFFFF}}, {4{32'hFFFFFFFF}}, 1'b1, 1, 1,
              mk({4{32'hFFFFFFFF}}, 1'b1, 1'b1, 1'b0));
        drain();

`ifdef BK_ADD_SEQ_OVF_EN
        issue(1'b0, 128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, 1, 1,
              mk(128'h80000000_00000000_00000000_00000000, 1'b0, 1'b0, 1'b1));
        drain();
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
